// File: rtl/cmd_arbiter.sv
// cmd_arbiter: merges debounced button pulses and UART command bytes into single-cycle
// one-hot command pulses, keeps a shadow of the stopwatch run flag and display mode,
// and optionally echoes each UART command back through the TX handshake.
module cmd_arbiter #(
  parameter bit         ECHO_EN  = 1'b1,
  parameter logic [7:0] ERR_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  input  logic       i_tx_busy,
  output logic [9:0] o_com_data,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_mode,
  output logic       o_run,
  output logic       o_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StEchoReq, StEchoWait} state_e;
  typedef enum logic [1:0] {SrcClear, SrcRun, SrcMode, SrcUart} src_e;

  state_e     r_state;
  src_e       r_src;
  logic [2:0] r_btn_pend;  // {mode, clear, run}
  logic       r_uart_val;
  logic [6:0] r_uart_code;
  logic [7:0] r_uart_byte;
  logic [9:0] r_com;
  logic       r_run;
  logic       r_mode;
  logic       r_err;
  logic [7:0] r_echo_byte;
  logic [7:0] r_tx_data;
  logic       r_seen_busy;
  logic [1:0] r_wait_cnt;

  logic [7:0] w_rx_fold;
  logic [6:0] w_rx_code;
  logic       w_issue;
  logic       w_clr_run;
  logic       w_clr_clear;
  logic       w_clr_mode;
  logic       w_echo_done;
  logic       w_clr_uart;
  logic       w_rx_drop;
  logic       w_any;
  src_e       w_src;
  logic [9:0] w_code;
  logic [7:0] w_echo_byte;

  // Clearing bit 5 folds ASCII lower case onto upper case; only exact letter codes match.
  assign w_rx_fold = i_rx_data & 8'hDF;

  // Decode a received byte into its one-hot command code (zero = unknown byte).
  always_comb begin
    w_rx_code = 7'd0;
    case (w_rx_fold)
      8'h52:   w_rx_code = 7'h01;  // R run
      8'h53:   w_rx_code = 7'h02;  // S stop
      8'h43:   w_rx_code = 7'h04;  // C clear
      8'h4D:   w_rx_code = 7'h08;  // M mode
      8'h48:   w_rx_code = 7'h10;  // H hour+
      8'h4E:   w_rx_code = 7'h20;  // N min+
      8'h45:   w_rx_code = 7'h40;  // E sec+
      default: w_rx_code = 7'd0;
    endcase
  end

  assign w_issue     = (r_state == StIssue);
  assign w_clr_run   = w_issue && (r_src == SrcRun);
  assign w_clr_clear = w_issue && (r_src == SrcClear);
  assign w_clr_mode  = w_issue && (r_src == SrcMode);
  assign w_echo_done = (r_state == StEchoWait) && !i_tx_busy &&
                       (r_seen_busy || (r_wait_cnt == 2'd3));
  // The UART slot stays occupied until its echo has completed, so bytes arriving
  // while a command is still being echoed count as an overrun.
  assign w_clr_uart  = (w_issue && (r_src == SrcUart) && !ECHO_EN) || w_echo_done;
  assign w_rx_drop   = i_rx_done && r_uart_val && !w_clr_uart;
  assign w_any       = (|r_btn_pend) || r_uart_val;
  assign w_echo_byte = (r_uart_code == 7'd0) ? ERR_CHAR : r_uart_byte;

  // Pick the highest-priority pending source: clear > run > mode > UART.
  always_comb begin
    w_src  = SrcUart;
    w_code = {3'b000, r_uart_code};
    if (r_btn_pend[1]) begin
      w_src  = SrcClear;
      w_code = 10'h004;
    end else if (r_btn_pend[0]) begin
      w_src  = SrcRun;
      w_code = r_run ? 10'h002 : 10'h001;
    end else if (r_btn_pend[2]) begin
      w_src  = SrcMode;
      w_code = 10'h008;
    end
  end

  // Sticky pending flags; a new event in the same cycle as its clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_pend  <= 3'b000;
      r_uart_val  <= 1'b0;
      r_uart_code <= 7'd0;
      r_uart_byte <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_btn_pend[0] <= i_btn_run   | (r_btn_pend[0] & ~w_clr_run);
      r_btn_pend[1] <= i_btn_clear | (r_btn_pend[1] & ~w_clr_clear);
      r_btn_pend[2] <= i_btn_mode  | (r_btn_pend[2] & ~w_clr_mode);
      if (i_rx_done && !w_rx_drop) begin
        r_uart_val  <= 1'b1;
        r_uart_code <= w_rx_code;
        r_uart_byte <= i_rx_data;
      end else if (w_clr_uart) begin
        r_uart_val <= 1'b0;
      end
      r_err <= i_rx_done && (w_rx_drop || (w_rx_code == 7'd0));
    end
  end

  // Arbitration FSM with registered command, shadow state and echo byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_src       <= SrcClear;
      r_com       <= 10'd0;
      r_run       <= 1'b0;
      r_mode      <= 1'b0;
      r_echo_byte <= 8'd0;
      r_tx_data   <= 8'd0;
      r_seen_busy <= 1'b0;
      r_wait_cnt  <= 2'd0;
    end else begin
      r_com <= 10'd0;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_src       <= w_src;
            r_com       <= w_code;
            r_echo_byte <= w_echo_byte;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          if (r_com[0]) r_run <= 1'b1;
          if (r_com[1] || r_com[2]) r_run <= 1'b0;
          if (r_com[3]) r_mode <= ~r_mode;
          r_state <= ((r_src == SrcUart) && ECHO_EN) ? StEchoReq : StIdle;
        end
        StEchoReq: begin
          if (!i_tx_busy) begin
            r_tx_data   <= r_echo_byte;
            r_seen_busy <= 1'b0;
            r_wait_cnt  <= 2'd0;
            r_state     <= StEchoWait;
          end
        end
        StEchoWait: begin
          if (i_tx_busy) begin
            r_seen_busy <= 1'b1;
          end else if (r_seen_busy || (r_wait_cnt == 2'd3)) begin
            r_state <= StIdle;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Start is combinational so the echo can leave one cycle after the command pulse.
  assign o_tx_start = (r_state == StEchoReq) && !i_tx_busy;
  assign o_tx_data  = o_tx_start ? r_echo_byte : r_tx_data;
  assign o_com_data = r_com;
  assign o_run      = r_run;
  assign o_mode     = r_mode;
  assign o_err      = r_err;

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model of the arbiter's command/echo rules.
module tb_cmd_arbiter;
  localparam bit         EchoEn  = 1'b1;
  localparam logic [7:0] ErrChar = 8'h3F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_rx_data = 8'd0;
  logic       i_rx_done = 1'b0;
  logic       i_btn_run = 1'b0;
  logic       i_btn_clear = 1'b0;
  logic       i_btn_mode = 1'b0;
  logic       i_tx_busy;
  logic [9:0] o_com_data;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_mode;
  logic       o_run;
  logic       o_err;

  logic busy_force = 1'b0;
  logic tx_busy_auto = 1'b0;
  assign i_tx_busy = busy_force | tx_busy_auto;

  always #5 clk = ~clk;

  cmd_arbiter #(.ECHO_EN(EchoEn), .ERR_CHAR(ErrChar)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_btn_run  (i_btn_run),
    .i_btn_clear(i_btn_clear),
    .i_btn_mode (i_btn_mode),
    .i_tx_busy  (i_tx_busy),
    .o_com_data (o_com_data),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_mode     (o_mode),
    .o_run      (o_run),
    .o_err      (o_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs sampled mid-cycle, plus running logs for directed checks.
  logic [9:0] obs_com = '0;
  logic       obs_start = 1'b0;
  logic       obs_err = 1'b0;
  logic       obs_run = 1'b0;
  logic       obs_mode = 1'b0;
  logic [7:0] obs_txd = '0;
  logic [7:0] last_txd = '0;
  int         err_cnt = 0;
  int         start_cnt = 0;
  logic [9:0] com_log[$];

  always @(negedge clk) begin
    obs_com   = o_com_data;
    obs_start = o_tx_start;
    obs_err   = o_err;
    obs_run   = o_run;
    obs_mode  = o_mode;
    obs_txd   = o_tx_data;
    if (o_com_data != 10'd0) com_log.push_back(o_com_data);
    if (o_err) err_cnt++;
    if (o_tx_start) begin
      start_cnt++;
      last_txd = o_tx_data;
    end
  end

  // Simple UART TX stand-in: busy for tx_len cycles after each start (0 = never busy).
  int tx_len = 3;
  int tx_left = 0;
  always @(posedge clk) begin
    #1;
    if (obs_start && tx_len > 0) tx_left = tx_len;
    else if (tx_left > 0) tx_left--;
    tx_busy_auto = (tx_left > 0);
  end

  // Command letter table: index = command bit.
  function automatic int decode(input logic [7:0] b);
    string      letters;
    logic [7:0] up;
    letters = "RSCMHNE";
    up = (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
    for (int i = 0; i < 7; i++) if (letters[i] == up) return i;
    return -1;
  endfunction

  // Behavioural model: pending sets, one transaction in flight, shadow flags.
  bit         p_run, p_clr, p_mode, u_val;
  logic [7:0] u_byte;
  int         u_bit;
  bit         m_run, m_mode, cur_err;
  logic [9:0] cur_com, nxt_com;
  bit         issuing, echo_owed, watching, seen;
  int         waited, m_src;
  logic [7:0] echo_byte, txd_hold, e_txd;
  bit         e_start, c_run, c_clr, c_mode, c_u, drop;

  always @(posedge clk) begin
    if (rst) begin
      p_run = 0; p_clr = 0; p_mode = 0; u_val = 0; u_byte = 0; u_bit = -1;
      m_run = 0; m_mode = 0; cur_com = 0; cur_err = 0;
      issuing = 0; echo_owed = 0; watching = 0; seen = 0; waited = 0; m_src = 0;
      echo_byte = 0; txd_hold = 0;
    end else begin
      e_start = echo_owed && !i_tx_busy;
      e_txd   = e_start ? echo_byte : txd_hold;
      check_eq("com_data", obs_com, cur_com);
      check_eq("err", obs_err, cur_err);
      check_eq("tx_start", obs_start, e_start);
      check_eq("tx_data", obs_txd, e_txd);
      check_eq("run", obs_run, m_run);
      check_eq("mode", obs_mode, m_mode);
      c_run = 0; c_clr = 0; c_mode = 0; c_u = 0; nxt_com = 0;
      if (issuing) begin
        issuing = 0;
        if (cur_com[0]) m_run = 1;
        if (cur_com[1] || cur_com[2]) m_run = 0;
        if (cur_com[3]) m_mode = !m_mode;
        case (m_src)
          0: c_clr = 1;
          1: c_run = 1;
          2: c_mode = 1;
          default: if (EchoEn) echo_owed = 1; else c_u = 1;
        endcase
      end else if (echo_owed) begin
        if (!i_tx_busy) begin
          echo_owed = 0; txd_hold = echo_byte; watching = 1; seen = 0; waited = 0;
        end
      end else if (watching) begin
        if (i_tx_busy) seen = 1;
        else if (seen || waited == 3) begin watching = 0; c_u = 1; end
        else waited++;
      end else if (p_clr || p_run || p_mode || u_val) begin
        issuing = 1;
        if (p_clr) begin m_src = 0; nxt_com = 10'h004; end
        else if (p_run) begin m_src = 1; nxt_com = m_run ? 10'h002 : 10'h001; end
        else if (p_mode) begin m_src = 2; nxt_com = 10'h008; end
        else begin
          m_src = 3;
          nxt_com = (u_bit < 0) ? 10'd0 : 10'(1 << u_bit);
          echo_byte = (u_bit < 0) ? ErrChar : u_byte;
        end
      end
      drop   = i_rx_done && u_val && !c_u;
      p_run  = (p_run && !c_run) || i_btn_run;
      p_clr  = (p_clr && !c_clr) || i_btn_clear;
      p_mode = (p_mode && !c_mode) || i_btn_mode;
      if (i_rx_done && !drop) begin
        u_val = 1; u_byte = i_rx_data; u_bit = decode(i_rx_data);
      end else if (c_u) u_val = 0;
      cur_err = i_rx_done && (drop || decode(i_rx_data) < 0);
      cur_com = nxt_com;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit run, input bit clr, input bit mode, input bit rx,
                       input logic [7:0] b);
    i_btn_run = run; i_btn_clear = clr; i_btn_mode = mode; i_rx_done = rx; i_rx_data = b;
    tick(1);
    i_btn_run = 0; i_btn_clear = 0; i_btn_mode = 0; i_rx_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         e0, s0;
  string      known;
  logic [7:0] rb;

  initial begin
    known = "RSCMHNErscmhne";
    tick(3);
    check_eq("rst_com", o_com_data, 10'd0);
    check_eq("rst_start", o_tx_start, 1'b0);
    check_eq("rst_run", o_run, 1'b0);
    check_eq("rst_mode", o_mode, 1'b0);
    check_eq("rst_err", o_err, 1'b0);
    rst = 1'b0;
    tick(7);

    // Run button: two-cycle latency, then toggles to stop.
    drive(1, 0, 0, 0, 8'd0);
    @(negedge clk); check_eq("run_lat_n1", o_com_data, 10'd0);
    @(negedge clk); check_eq("run_lat_n2", o_com_data, 10'h001);
    @(posedge clk); #1;
    tick(3);
    check_eq("run_set", o_run, 1'b1);
    com_log.delete();
    drive(1, 0, 0, 0, 8'd0);
    tick(5);
    check_eq("stop_cnt", com_log.size(), 1);
    if (com_log.size() > 0) check_eq("stop_code", com_log[0], 10'h002);
    check_eq("stop_run", o_run, 1'b0);

    // UART 'c' with a 20-cycle transmitter.
    tx_len = 20; com_log.delete(); s0 = start_cnt;
    drive(0, 0, 0, 1, 8'h63);
    tick(35);
    check_eq("c_code", (com_log.size() > 0) ? com_log[0] : 10'h3FF, 10'h004);
    check_eq("c_echo_cnt", start_cnt - s0, 1);
    check_eq("c_echo_byte", last_txd, 8'h63);

    // Clear, mode and 'S' together.
    com_log.delete();
    drive(0, 1, 1, 1, 8'h53);
    tick(40);
    check_eq("sim_cnt", com_log.size(), 3);
    if (com_log.size() == 3) begin
      check_eq("sim_0", com_log[0], 10'h004);
      check_eq("sim_1", com_log[1], 10'h008);
      check_eq("sim_2", com_log[2], 10'h002);
    end
    check_eq("sim_mode", o_mode, 1'b1);

    // Unknown 'Z', then a byte that overruns the slot during its echo.
    com_log.delete(); e0 = err_cnt; s0 = start_cnt;
    drive(0, 0, 0, 1, 8'h5A);
    tick(5);
    drive(0, 0, 0, 1, 8'h72);
    tick(40);
    check_eq("z_err_cnt", err_cnt - e0, 2);
    check_eq("z_no_cmd", com_log.size(), 0);
    check_eq("z_echo_cnt", start_cnt - s0, 1);
    check_eq("z_echo_byte", last_txd, 8'h3F);

    // Busy held 50 cycles while an echo is owed; a mode press waits behind it.
    com_log.delete(); s0 = start_cnt;
    busy_force = 1'b1;
    drive(0, 0, 0, 1, 8'h68);
    tick(6);
    drive(0, 0, 1, 0, 8'd0);
    tick(44);
    check_eq("busy_deferred", start_cnt - s0, 0);
    busy_force = 1'b0;
    tick(40);
    check_eq("busy_echo_cnt", start_cnt - s0, 1);
    check_eq("busy_echo_byte", last_txd, 8'h68);
    check_eq("busy_order_cnt", com_log.size(), 2);
    if (com_log.size() == 2) begin
      check_eq("busy_order_0", com_log[0], 10'h010);
      check_eq("busy_order_1", com_log[1], 10'h008);
    end

    // Reset while waiting for the echo to finish.
    drive(1, 0, 0, 0, 8'd0);
    tick(5);
    drive(0, 0, 0, 1, 8'h45);
    for (int k = 0; k < 30 && !watching; k++) tick(1);
    check_eq("echo_wait_reached", watching, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_com", o_com_data, 10'd0);
    check_eq("arst_start", o_tx_start, 1'b0);
    check_eq("arst_txd", o_tx_data, 8'd0);
    check_eq("arst_run", o_run, 1'b0);
    check_eq("arst_mode", o_mode, 1'b0);
    check_eq("arst_err", o_err, 1'b0);
    com_log.delete(); s0 = start_cnt;
    tick(2);
    rst = 1'b0;
    tick(30);
    check_eq("post_rst_cmd", com_log.size(), 0);
    check_eq("post_rst_start", start_cnt - s0, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) tx_len = $urandom_range(0, 6);
      if ($urandom_range(0, 19) == 0) busy_force = !busy_force;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      i_btn_run   = ($urandom_range(0, 15) == 0);
      i_btn_clear = ($urandom_range(0, 23) == 0);
      i_btn_mode  = ($urandom_range(0, 19) == 0);
      i_rx_done   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) rb = known[$urandom_range(0, 13)];
      else rb = 8'($urandom_range(0, 255));
      i_rx_data = rb;
      tick(1);
    end
    i_btn_run = 0; i_btn_clear = 0; i_btn_mode = 0; i_rx_done = 0; busy_force = 0;
    tick(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
